prog_loader_mem: RTL
====================

# prog_loader_mem

Program-store block that sits directly upstream of the control unit's fetch path. It holds the 256-byte program image and drives `data_program` from `addr_program` combinationally, which gives the control unit the same-cycle fetch it relies on. A byte-stream load port with a valid/ready handshake fills the image, and a length/checksum frame guards it. The block keeps the CPU in reset until a verified image is present.

## Interface
Parameters:
- `FILL`, default `8'h00` — byte returned for any unloaded or out-of-range address (NOP opcode).

Ports:
- `clk` in 1 — single clock; all state updates on posedge.
- `rst_n` in 1 — synchronous, active-low reset.
- `addr_program` in 8 — fetch address from the CU program counter.
- `data_program` out 8 — fetched instruction byte (combinational).
- `load_valid` in 1 — loader presents `load_data`.
- `load_ready` out 1 — block accepts a byte this cycle.
- `load_data` in 8 — frame byte.
- `run` out 1 — verified image present; fetch enabled.
- `cpu_rst_n` out 1 — active-low reset to the CU; equals `run`.
- `load_err` out 1 — sticky checksum failure.
- `prog_len` out 9 — committed image length, 0..256.

## Operation
- Reset values: `run`=0, `cpu_rst_n`=0, `load_err`=0, `prog_len`=0, `load_ready`=1, state=IDLE, write pointer=0, running sum=0. Reset does not clear RAM contents. With `prog_len`=0, every fetch returns `FILL`.
- Frame format: byte 0 = count N (`8'h00` encodes 256). Bytes 1..N = payload, written to addresses 0..N-1. Final byte = checksum, defined as (N byte + all payload bytes) mod 256.
- Transfer rule: a byte transfers on a posedge with `load_valid && load_ready`. With `load_valid` low, nothing happens and the state holds.
- State machine:
  - IDLE (ready=1): on transfer, latch N (0 becomes 256), sum ← byte, ptr ← 0. Go to LOAD.
  - LOAD (ready=1): on transfer, mem[ptr] ← byte, sum += byte, ptr++. After the Nth payload byte, go to CHECK.
  - CHECK (ready=1): on transfer, compare the byte with sum[7:0].
    - Match: go to RUN, `prog_len` ← N, `run` ← 1, `cpu_rst_n` ← 1.
    - Mismatch: go to ERROR, `load_err` ← 1.
  - RUN (ready=0): fetch active. Stays here until reset.
  - ERROR (ready=0): `run`=0, `prog_len`=0. Stays here until reset.
- Fetch: `data_program` = mem[`addr_program`] when `run` && `addr_program` < `prog_len`; otherwise `FILL`. The compare is a 9-bit compare, so with `prog_len`=256 every address is valid.
- RAM writes happen only in LOAD. Reads use the fetch port only. No write path exists in RUN.
- Sum arithmetic is 8-bit and wraps modulo 256. The ptr is 9-bit internally.

## Timing
- Load throughput: one byte per cycle when `load_valid` is held high. Back-to-back transfers need no bubbles.
- Total frame: N+2 transfers. `run` and `cpu_rst_n` rise on the edge that accepts the checksum byte. The CU leaves reset on the next edge, with pc=0.
- `load_ready` falls on the same edge as the checksum transfer. That happens whether the result is RUN or ERROR.
- Fetch latency is zero cycles: `data_program` follows `addr_program` combinationally. The CU samples it on its next posedge.
- Reset mid-load:
  - `rst_n` low on any edge forces IDLE.
  - Partially written bytes remain in RAM but are unreachable, because `prog_len`=0.
  - `cpu_rst_n` is 0 on that edge.
- Reset while in RUN: the CU is held in reset from that edge on. A full new frame is required to restart.
- A `load_valid` pulse while in RUN or ERROR is ignored; no transfer occurs.
- Wrap-around: ptr never exceeds N. With N=256, the last payload byte lands at address 255.

## Test plan
- Nominal load: frame {03, 12, 00, 07, 1C}. The checksum 1C = 03+12+00+07. Required response:
  - `run` rises on the 5th transfer edge; `prog_len`=3; `load_err`=0.
  - Fetch at addresses 0, 1, 2 returns 12, 00, 07.
  - Fetch at address 3 returns 00 (`FILL`).
- Bad checksum: same frame with final byte 1D. Required response:
  - `load_err`=1, `run`=0, `cpu_rst_n`=0, `load_ready`=0.
  - Fetch at address 0 returns 00.
  - Further `load_valid` pulses cause no change.
- Full image: N byte 00, then 256 payload bytes with value = address. The checksum is 00 + sum(0..255) mod 256 = 80. Required response:
  - `prog_len`=256.
  - Fetch at address FF returns FF.
  - Every address returns its own value.
- Throttled handshake: the nominal frame with `load_valid` toggled 1-0-1-0. The result must be identical to the nominal load, with completion after 9 cycles.
- Reset mid-load: frame {04, AA, BB}, then `rst_n`=0 for 1 cycle, then the frame {01, 55, 56}. Required response:
  - `run`=1 and `prog_len`=1.
  - Fetch at address 0 returns 55.
  - Fetch at address 1 returns 00, even though BB is stale in RAM.
- Reset during RUN: after a nominal load, assert `rst_n`=0. Required response:
  - On that edge, `run`=0, `cpu_rst_n`=0, `load_ready`=1.
  - All fetches return 00 until the next frame is accepted.

Source files
------------

// File: rtl/prog_loader_mem.sv
// prog_loader_mem: 256-byte program store for the control unit's fetch path.
// A framed byte stream (count, payload, checksum) fills the image. The image
// is only exposed to fetch, and the CPU only released from reset, after the
// checksum over count + payload matches.
module prog_loader_mem #(
    parameter logic [7:0] FILL = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] addr_program,
    output logic [7:0] data_program,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [7:0] load_data,
    output logic       run,
    output logic       cpu_rst_n,
    output logic       load_err,
    output logic [8:0] prog_len
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_t;

    state_t     state_q, state_d;
    logic [8:0] len_q, len_d;          // frame length N, 1..256
    logic [8:0] ptr_q, ptr_d;          // next payload write address
    logic [7:0] sum_q, sum_d;          // running mod-256 checksum
    logic [8:0] prog_len_q, prog_len_d;
    logic       run_q, run_d;
    logic       err_q, err_d;

    logic [7:0] mem [256];
    logic       xfer;
    logic       mem_we;

    // State and control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its peers.
        if (!rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            ptr_q      <= '0;
            sum_q      <= '0;
            prog_len_q <= '0;
            run_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            ptr_q      <= ptr_d;
            sum_q      <= sum_d;
            prog_len_q <= prog_len_d;
            run_q      <= run_d;
            err_q      <= err_d;
        end
    end

    // Next-state and datapath update for the frame parser.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        len_d      = len_q;
        ptr_d      = ptr_q;
        sum_d      = sum_q;
        prog_len_d = prog_len_q;
        run_d      = run_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    // A count byte of zero encodes a full 256-byte image.
                    len_d   = (load_data == 8'h00) ? 9'd256 : {1'b0, load_data};
                    sum_d   = load_data;
                    ptr_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    ptr_d = ptr_q + 9'd1;
                    sum_d = sum_q + load_data;
                    if (ptr_q == len_q - 9'd1) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (xfer) begin
                    if (load_data == sum_q) begin
                        state_d    = S_RUN;
                        prog_len_d = len_q;
                        run_d      = 1'b1;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_RUN, S_ERROR: begin
                // Terminal until reset.
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake, write strobe and combinational fetch port.
    always_comb begin
        load_ready   = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_CHECK);
        xfer         = load_valid && load_ready;
        mem_we       = xfer && (state_q == S_LOAD) && rst_n;
        run          = run_q;
        cpu_rst_n    = run_q;
        load_err     = err_q;
        prog_len     = prog_len_q;
        data_program = FILL;
        if (run_q && ({1'b0, addr_program} < prog_len_q)) begin
            data_program = mem[addr_program];
        end
    end

    // Payload write port; only active while loading.
    always_ff @(posedge clk) begin
        // NOTE: the RAM is deliberately not reset; prog_len gating makes
        // stale contents unreachable, and a reset would block RAM inference.
        if (mem_we) begin
            mem[ptr_q[7:0]] <= load_data;
        end
    end

endmodule
